operand_forward_stage: RTL and testbench
========================================

Name: operand_forward_stage

Overview:
- Stage 6 pipeline register directly downstream of the stage-5 register file; consumes its registered rs1/rs2 read data.
- Resolves RAW hazards by bypassing results from execute, memory and writeback.
- Covers the register file's same-edge write/read blind spot with a one-entry late-writeback register.
- Detects load-use hazards, stalls upstream and presents valid/ready-handshaked operands to execute.

Parameters:
WIDTH, 32, operand/data width (word)
TAG_W, 5, register tag width (tag)

Ports:
clock  in  1  rising-edge clock
reset_n  in  1  asynchronous active-low reset
flush  in  1  synchronous squash of the held entry (branch redirect)
in_valid  in  1  upstream entry valid; tags aligned with rs*_read (upstream delays tags one cycle)
in_ready  out  1  stage can accept this cycle
in_rs1  in  TAG_W  source tag 1 (0 when unused)
in_rs2  in  TAG_W  source tag 2 (0 when unused)
in_rd  in  TAG_W  destination tag
rs1_read  in  WIDTH  register file read data 1
rs2_read  in  WIDTH  register file read data 2
ex_valid  in  1  execute stage holds a result-producing instruction
ex_is_load  in  1  execute instruction is a load (value not yet available)
ex_rd  in  TAG_W  execute destination
ex_value  in  WIDTH  execute ALU result
mem_valid  in  1  memory stage result valid
mem_rd  in  TAG_W  memory destination
mem_value  in  WIDTH  memory result (incl. load data)
wb_valid  in  1  writeback enable (same signal as register file register_writeback)
wb_rd  in  TAG_W  writeback destination
wb_value  in  WIDTH  writeback value
out_valid  out  1  operands valid to execute
out_ready  in  1  execute can accept
out_op1  out  WIDTH  resolved operand 1
out_op2  out  WIDTH  resolved operand 2
out_rd  out  TAG_W  registered destination
load_use_stall  out  1  combinational load-use hazard indicator

Behaviour:
- Reset (reset_n=0, async): out_valid=0, out_op1=0, out_op2=0, out_rd=0, late-wb valid=0; all clear immediately, including mid-transfer.
- Late-wb register:
  - Every edge captures lw_valid = wb_valid && wb_rd!=0, plus lw_rd=wb_rd, lw_value=wb_value.
  - Covers the register file returning the pre-write value for a tag written on the same edge it was read.
  - Not cleared by flush.
- Per-source resolution, combinational, for tag t:
  - t==0 -> 0.
  - Else first match in priority order: ex (ex_valid && !ex_is_load && ex_rd==t) -> mem -> wb -> late-wb -> rs*_read.
  - Tag 0 never matches any bypass source.
- Hazard and handshake:
  - load_use_stall = in_valid && ex_valid && ex_is_load && ex_rd!=0 && (ex_rd==in_rs1 || ex_rd==in_rs2).
  - in_ready = (!out_valid || out_ready) && !load_use_stall && !flush.
  - Accept = in_valid && in_ready. On accept, next edge: out_valid=1, out_op1/out_op2=resolved values, out_rd=in_rd.
- Stall:
  - If load_use_stall && (!out_valid || out_ready), next edge out_valid=0 (bubble); upstream holds its entry.
  - Next cycle the load sits in mem and resolves via mem bypass; the stall lasts exactly 1 cycle.
- Backpressure: out_valid && !out_ready && !flush -> all outputs hold unchanged.
- Flush (sync) has priority over accept and hold: next edge out_valid=0, out_op1/out_op2/out_rd unchanged.
- Latency: exactly 1 cycle from accept to out_valid; throughput 1/cycle when hazard-free with out_ready=1.

Test Plan:
- Async reset: with out_valid=1, drop reset_n between edges -> out_valid=0 and out_op1=0 before the next edge.
- Bypass priority: in_rs1=5, rs1_read=0x11, ex rd=5 value 0xAA, mem rd=5 value 0xBB -> out_op1=0xAA; with ex_valid=0 -> out_op1=0xBB.
- Late-wb: wb writes x7=0x1234 on edge T while x7 is read (rs2_read=0x0 next cycle); in_rs2=7 in cycle T+1 -> out_op2=0x1234.
- Load-use: ex_is_load, ex_rd=3, in_rs1=3 -> load_use_stall=1, in_ready=0, bubble (out_valid=0). Next cycle mem_rd=3, mem_value=0x55 -> accept, out_op1=0x55.
- x0: in_rs1=0, ex_is_load=1, ex_rd=0, ex_value=0xFFFF -> no stall, out_op1=0.
- Backpressure + flush: out_valid=1, out_ready=0 for 3 cycles -> outputs stable, in_ready=0. Assert flush -> out_valid=0 next edge.

Source files
------------

// File: rtl/operand_forward_stage.sv
// Operand forwarding stage: resolves rs1/rs2 against in-flight results,
// covers the register file same-edge write/read gap with a late-writeback
// entry, and inserts a one-cycle bubble on load-use hazards.

// Per-source resolver: picks the youngest matching producer for one tag.
module operand_forward_resolve #(
  parameter int WIDTH = 32,
  parameter int TAG_W = 5
) (
  input  logic [TAG_W-1:0] tag,
  input  logic [WIDTH-1:0] rf_data,
  input  logic             ex_valid,
  input  logic             ex_is_load,
  input  logic [TAG_W-1:0] ex_rd,
  input  logic [WIDTH-1:0] ex_value,
  input  logic             mem_valid,
  input  logic [TAG_W-1:0] mem_rd,
  input  logic [WIDTH-1:0] mem_value,
  input  logic             wb_valid,
  input  logic [TAG_W-1:0] wb_rd,
  input  logic [WIDTH-1:0] wb_value,
  input  logic             lw_valid,
  input  logic [TAG_W-1:0] lw_rd,
  input  logic [WIDTH-1:0] lw_value,
  output logic [WIDTH-1:0] value
);

  // Priority mux: x0 first, then ex > mem > wb > late-wb > register file.
  always_comb begin
    value = rf_data;
    if (tag == '0)                                  value = '0;
    else if (ex_valid && !ex_is_load && ex_rd == tag) value = ex_value;
    else if (mem_valid && mem_rd == tag)            value = mem_value;
    else if (wb_valid && wb_rd == tag)              value = wb_value;
    else if (lw_valid && lw_rd == tag)              value = lw_value;
  end

endmodule

module operand_forward_stage #(
  parameter int WIDTH = 32,
  parameter int TAG_W = 5
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [TAG_W-1:0] in_rs1,
  input  logic [TAG_W-1:0] in_rs2,
  input  logic [TAG_W-1:0] in_rd,
  input  logic [WIDTH-1:0] rs1_read,
  input  logic [WIDTH-1:0] rs2_read,
  input  logic             ex_valid,
  input  logic             ex_is_load,
  input  logic [TAG_W-1:0] ex_rd,
  input  logic [WIDTH-1:0] ex_value,
  input  logic             mem_valid,
  input  logic [TAG_W-1:0] mem_rd,
  input  logic [WIDTH-1:0] mem_value,
  input  logic             wb_valid,
  input  logic [TAG_W-1:0] wb_rd,
  input  logic [WIDTH-1:0] wb_value,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_op1,
  output logic [WIDTH-1:0] out_op2,
  output logic [TAG_W-1:0] out_rd,
  output logic             load_use_stall
);

  localparam int NUM_SRC = 2;

  logic             lw_valid;
  logic [TAG_W-1:0] lw_rd;
  logic [WIDTH-1:0] lw_value;

  logic [NUM_SRC-1:0][TAG_W-1:0] src_tag;
  logic [NUM_SRC-1:0][WIDTH-1:0] src_read;
  logic [NUM_SRC-1:0][WIDTH-1:0] src_val;

  logic accept;
  logic drain_ok;

  assign src_tag  = {in_rs2, in_rs1};
  assign src_read = {rs2_read, rs1_read};

  genvar g;
  generate
    for (g = 0; g < NUM_SRC; g++) begin : g_src
      operand_forward_resolve #(.WIDTH(WIDTH), .TAG_W(TAG_W)) u_res (
        .tag        (src_tag[g]),
        .rf_data    (src_read[g]),
        .ex_valid   (ex_valid),
        .ex_is_load (ex_is_load),
        .ex_rd      (ex_rd),
        .ex_value   (ex_value),
        .mem_valid  (mem_valid),
        .mem_rd     (mem_rd),
        .mem_value  (mem_value),
        .wb_valid   (wb_valid),
        .wb_rd      (wb_rd),
        .wb_value   (wb_value),
        .lw_valid   (lw_valid),
        .lw_rd      (lw_rd),
        .lw_value   (lw_value),
        .value      (src_val[g])
      );
    end
  endgenerate

  // A load in execute has no value yet; any consumer of its tag must wait.
  assign load_use_stall = in_valid && ex_valid && ex_is_load && (ex_rd != '0) &&
                          ((ex_rd == in_rs1) || (ex_rd == in_rs2));

  assign drain_ok = !out_valid || out_ready;
  assign in_ready = drain_ok && !load_use_stall && !flush;
  assign accept   = in_valid && in_ready;

  // Late-writeback entry: remembers last cycle's write so a same-edge read
  // of stale register file data is corrected. Flush does not touch it.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      lw_valid <= 1'b0;
      lw_rd    <= '0;
      lw_value <= '0;
    end else begin
      lw_valid <= wb_valid && (wb_rd != '0);
      lw_rd    <= wb_rd;
      lw_value <= wb_value;
    end
  end

  // Output register: flush > accept > drain/bubble > hold under backpressure.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      out_valid <= 1'b0;
      out_op1   <= '0;
      out_op2   <= '0;
      out_rd    <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_op1   <= src_val[0];
      out_op2   <= src_val[1];
      out_rd    <= in_rd;
    end else if (drain_ok) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_operand_forward_stage.sv
// Directed bench for operand_forward_stage: vector table plus hand sequences.
module tb_operand_forward_stage;

  logic        clock, reset_n, flush, in_valid, in_ready;
  logic [4:0]  in_rs1, in_rs2, in_rd, ex_rd, mem_rd, wb_rd, out_rd;
  logic [31:0] rs1_read, rs2_read, ex_value, mem_value, wb_value, out_op1, out_op2;
  logic        ex_valid, ex_is_load, mem_valid, wb_valid, out_valid, out_ready;
  logic        load_use_stall;

  int n_cmp = 0;
  int n_bad = 0;

  operand_forward_stage #(.WIDTH(32), .TAG_W(5)) dut (
    .clock(clock), .reset_n(reset_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd),
    .rs1_read(rs1_read), .rs2_read(rs2_read),
    .ex_valid(ex_valid), .ex_is_load(ex_is_load), .ex_rd(ex_rd), .ex_value(ex_value),
    .mem_valid(mem_valid), .mem_rd(mem_rd), .mem_value(mem_value),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_value(wb_value),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_op1(out_op1), .out_op2(out_op2), .out_rd(out_rd),
    .load_use_stall(load_use_stall)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [4:0]  rs1, rs2, rd;
    logic [31:0] r1, r2;
    logic        exv, exl;
    logic [4:0]  exrd;
    logic [31:0] exval;
    logic        memv;
    logic [4:0]  memrd;
    logic [31:0] memval;
    logic        wbv;
    logic [4:0]  wbrd;
    logic [31:0] wbval;
    logic        stall;
    logic [31:0] op1, op2;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    in_valid = 0; in_rs1 = 0; in_rs2 = 0; in_rd = 0; rs1_read = 0; rs2_read = 0;
    ex_valid = 0; ex_is_load = 0; ex_rd = 0; ex_value = 0;
    mem_valid = 0; mem_rd = 0; mem_value = 0;
    wb_valid = 0; wb_rd = 0; wb_value = 0;
    flush = 0; out_ready = 1;
  endtask

  initial begin
    //          rs1 rs2 rd   r1        r2       exv exl exrd exval      memv memrd memval     wbv wbrd wbval     stall op1       op2
    vecs[0] = '{5'd1,5'd2,5'd10,32'h11,32'h22, 1'b0,1'b0,5'd0,32'h0,    1'b0,5'd0,32'h0,     1'b0,5'd0,32'h0,    1'b0,32'h11,  32'h22};
    vecs[1] = '{5'd5,5'd6,5'd11,32'h11,32'h66, 1'b1,1'b0,5'd5,32'hAA,   1'b1,5'd5,32'hBB,    1'b0,5'd0,32'h0,    1'b0,32'hAA,  32'h66};
    vecs[2] = '{5'd5,5'd6,5'd11,32'h11,32'h66, 1'b0,1'b0,5'd5,32'hAA,   1'b1,5'd5,32'hBB,    1'b0,5'd0,32'h0,    1'b0,32'hBB,  32'h66};
    vecs[3] = '{5'd4,5'd9,5'd12,32'h1, 32'h2,  1'b1,1'b0,5'd7,32'h77,   1'b1,5'd9,32'h99,    1'b1,5'd4,32'h44,   1'b0,32'h44,  32'h99};
    vecs[4] = '{5'd0,5'd2,5'd13,32'h123,32'h22,1'b1,1'b1,5'd0,32'hFFFF, 1'b0,5'd0,32'h0,     1'b0,5'd0,32'h0,    1'b0,32'h0,   32'h22};
    vecs[5] = '{5'd0,5'd0,5'd14,32'h5, 32'h6,  1'b1,1'b0,5'd0,32'hFFFF, 1'b1,5'd0,32'hEE,    1'b1,5'd0,32'hDD,   1'b0,32'h0,   32'h0};
    vecs[6] = '{5'd1,5'd2,5'd15,32'h11,32'h22, 1'b1,1'b1,5'd8,32'h88,   1'b0,5'd0,32'h0,     1'b0,5'd0,32'h0,    1'b0,32'h11,  32'h22};
    vecs[7] = '{5'd1,5'd8,5'd16,32'h11,32'h22, 1'b1,1'b1,5'd8,32'h88,   1'b0,5'd0,32'h0,     1'b0,5'd0,32'h0,    1'b1,32'h0,   32'h0};
    vecs[8] = '{5'd3,5'd3,5'd17,32'h33,32'h33, 1'b1,1'b0,5'd3,32'hAB,   1'b0,5'd0,32'h0,     1'b1,5'd3,32'hCD,   1'b0,32'hAB,  32'hAB};
    vecs[9] = '{5'd2,5'd5,5'd18,32'h1, 32'h55, 1'b0,1'b0,5'd0,32'h0,    1'b1,5'd2,32'h2222,  1'b1,5'd2,32'h3333, 1'b0,32'h2222,32'h55};

    idle_inputs();
    reset_n = 1;
    #2 reset_n = 0;
    #1;
    check("reset out_valid", {31'b0, out_valid}, 32'h0);
    check("reset out_op1", out_op1, 32'h0);
    check("reset out_op2", out_op2, 32'h0);
    check("reset out_rd", {27'b0, out_rd}, 32'h0);
    step();
    step();
    reset_n = 1;
    step();

    // Table-driven vectors, each preceded by an idle cycle to clear late-wb.
    for (int i = 0; i < 10; i++) begin
      idle_inputs();
      step();
      in_valid = 1; in_rs1 = vecs[i].rs1; in_rs2 = vecs[i].rs2; in_rd = vecs[i].rd;
      rs1_read = vecs[i].r1; rs2_read = vecs[i].r2;
      ex_valid = vecs[i].exv; ex_is_load = vecs[i].exl; ex_rd = vecs[i].exrd; ex_value = vecs[i].exval;
      mem_valid = vecs[i].memv; mem_rd = vecs[i].memrd; mem_value = vecs[i].memval;
      wb_valid = vecs[i].wbv; wb_rd = vecs[i].wbrd; wb_value = vecs[i].wbval;
      #1;
      check($sformatf("vec%0d stall", i), {31'b0, load_use_stall}, {31'b0, vecs[i].stall});
      check($sformatf("vec%0d in_ready", i), {31'b0, in_ready}, {31'b0, !vecs[i].stall});
      step();
      check($sformatf("vec%0d out_valid", i), {31'b0, out_valid}, {31'b0, !vecs[i].stall});
      if (!vecs[i].stall) begin
        check($sformatf("vec%0d op1", i), out_op1, vecs[i].op1);
        check($sformatf("vec%0d op2", i), out_op2, vecs[i].op2);
        check($sformatf("vec%0d rd", i), {27'b0, out_rd}, {27'b0, vecs[i].rd});
      end
    end

    // Late writeback: x7 written on edge T (with flush active), read stale next cycle.
    idle_inputs();
    step();
    wb_valid = 1; wb_rd = 7; wb_value = 32'h1234; flush = 1;
    step();
    idle_inputs();
    in_valid = 1; in_rs2 = 7; rs2_read = 32'h0; in_rs1 = 1; rs1_read = 32'h10; in_rd = 7;
    step();
    check("latewb out_valid", {31'b0, out_valid}, 32'h1);
    check("latewb op2", out_op2, 32'h1234);
    check("latewb op1", out_op1, 32'h10);

    // Load-use: one-cycle bubble, then mem bypass supplies the load data.
    idle_inputs();
    step();
    in_valid = 1; in_rs1 = 3; in_rs2 = 0; in_rd = 9; rs1_read = 32'h33;
    ex_valid = 1; ex_is_load = 1; ex_rd = 3; ex_value = 32'hDEAD;
    #1;
    check("lu stall", {31'b0, load_use_stall}, 32'h1);
    check("lu in_ready", {31'b0, in_ready}, 32'h0);
    step();
    check("lu bubble", {31'b0, out_valid}, 32'h0);
    ex_valid = 0; ex_is_load = 0; ex_rd = 0;
    mem_valid = 1; mem_rd = 3; mem_value = 32'h55;
    #1;
    check("lu stall clear", {31'b0, load_use_stall}, 32'h0);
    check("lu in_ready clear", {31'b0, in_ready}, 32'h1);
    step();
    check("lu out_valid", {31'b0, out_valid}, 32'h1);
    check("lu op1", out_op1, 32'h55);

    // Backpressure for 3 cycles, then flush.
    idle_inputs();
    step();
    in_valid = 1; in_rs1 = 1; rs1_read = 32'h11; in_rs2 = 2; rs2_read = 32'h22; in_rd = 20;
    step();
    check("bp load op1", out_op1, 32'h11);
    out_ready = 0; rs1_read = 32'h99; rs2_read = 32'h98; in_rd = 21;
    for (int c = 0; c < 3; c++) begin
      #1;
      check($sformatf("bp%0d in_ready", c), {31'b0, in_ready}, 32'h0);
      step();
      check($sformatf("bp%0d out_valid", c), {31'b0, out_valid}, 32'h1);
      check($sformatf("bp%0d op1", c), out_op1, 32'h11);
      check($sformatf("bp%0d op2", c), out_op2, 32'h22);
      check($sformatf("bp%0d rd", c), {27'b0, out_rd}, 32'd20);
    end
    flush = 1;
    #1;
    check("flush in_ready", {31'b0, in_ready}, 32'h0);
    step();
    check("flush out_valid", {31'b0, out_valid}, 32'h0);
    check("flush op1 kept", out_op1, 32'h11);
    check("flush rd kept", {27'b0, out_rd}, 32'd20);
    // Flush beats accept even with downstream ready.
    out_ready = 1;
    step();
    check("flush2 out_valid", {31'b0, out_valid}, 32'h0);
    check("flush2 op1 kept", out_op1, 32'h11);
    flush = 0;

    // Back-to-back accepts at full throughput.
    rs1_read = 32'hA1; in_rd = 22;
    step();
    check("tp0 op1", out_op1, 32'hA1);
    rs1_read = 32'hA2; in_rd = 23;
    step();
    check("tp1 out_valid", {31'b0, out_valid}, 32'h1);
    check("tp1 op1", out_op1, 32'hA2);
    check("tp1 rd", {27'b0, out_rd}, 32'd23);

    // Asynchronous reset between edges.
    #3 reset_n = 0;
    #1;
    check("areset out_valid", {31'b0, out_valid}, 32'h0);
    check("areset op1", out_op1, 32'h0);
    check("areset op2", out_op2, 32'h0);
    check("areset rd", {27'b0, out_rd}, 32'h0);
    idle_inputs();
    reset_n = 1;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
